// File: rtl/pkt_buff_ring_alloc_pkg.sv
// Shared defaults for the L1 packet-buffer ring allocator.
package pkt_buff_ring_alloc_pkg;

    localparam int unsigned DefaultBuffMemLength = 512;
    localparam int unsigned DefaultMemSlotSize   = 64;

endpackage

// File: rtl/pkt_buff_ring_alloc.sv
// Ring-buffer allocator for the cluster L1 packet buffer: hands out contiguous
// slot regions at the tail and retires freed regions in order from the head.
module pkt_buff_ring_alloc
    import pkt_buff_ring_alloc_pkg::*;
#(
    parameter int unsigned BuffMemLength = DefaultBuffMemLength,
    parameter int unsigned MemSlotSize   = DefaultMemSlotSize,
    localparam int unsigned SW           = $clog2(BuffMemLength)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          alloc_valid_i,
    output logic          alloc_ready_o,
    input  logic [SW:0]   alloc_size_i,
    output logic [SW-1:0] alloc_index_o,
    input  logic          free_valid_i,
    input  logic [SW-1:0] free_index_i,
    input  logic [SW:0]   free_size_i,
    output logic [SW:0]   free_space_o
);

    localparam int unsigned N         = BuffMemLength / MemSlotSize;
    localparam int unsigned IW        = $clog2(N);
    localparam int unsigned CW        = IW + 1;
    localparam int unsigned SlotShift = $clog2(MemSlotSize);
    localparam int unsigned KW        = SW + 2 - SlotShift;

    typedef logic [IW-1:0] slot_idx_t;
    typedef logic [CW-1:0] slot_cnt_t;

    // Byte count to slot count, rounded up; wide enough for any input value.
    function automatic logic [KW-1:0] to_slots(input logic [SW:0] bytes);
        logic [SW+1:0] rounded;
        rounded = (SW+2)'(bytes) + (SW+2)'(MemSlotSize - 1);
        return KW'(rounded >> SlotShift);
    endfunction

    slot_idx_t    head_q;
    slot_idx_t    tail_q;
    slot_cnt_t    used_q;
    slot_cnt_t    len_q [N];
    logic [N-1:0] freed_q;

    logic          empty;
    logic          full;
    slot_idx_t     head_eff;
    slot_idx_t     tail_eff;
    slot_cnt_t     tail_room;
    slot_cnt_t     fs_slots;
    logic [KW-1:0] alloc_slots_w;
    logic [KW-1:0] free_slots_w;
    slot_cnt_t     alloc_k;
    logic          alloc_wrap;
    logic          alloc_fire;
    slot_idx_t     alloc_start;
    slot_cnt_t     alloc_delta;
    logic          free_fire;
    slot_idx_t     free_slot;
    logic          retire;
    slot_cnt_t     retire_len;
    slot_cnt_t     used_d;

    // An empty ring always restarts at slot 0, whatever the stale pointers say.
    assign empty     = (used_q == '0);
    assign full      = (used_q == CW'(N));
    assign head_eff  = empty ? '0 : head_q;
    assign tail_eff  = empty ? '0 : tail_q;
    assign tail_room = CW'(N) - CW'(tail_eff);

    // Largest contiguous run: either after the tail or, by wrapping, before the head.
    always_comb begin
        fs_slots = '0;
        if (empty) begin
            fs_slots = CW'(N);
        end else if (full) begin
            fs_slots = '0;
        end else if (tail_eff > head_eff) begin
            fs_slots = (tail_room > CW'(head_eff)) ? tail_room : CW'(head_eff);
        end else if (tail_eff < head_eff) begin
            fs_slots = CW'(head_eff) - CW'(tail_eff);
        end
    end

    assign free_space_o  = (SW+1)'(fs_slots) << SlotShift;
    assign alloc_ready_o = (alloc_size_i <= free_space_o);

    assign alloc_slots_w = to_slots(alloc_size_i);
    assign alloc_k       = CW'(alloc_slots_w);
    assign alloc_wrap    = !empty && (tail_eff > head_eff) && (alloc_k > tail_room);
    assign alloc_start   = alloc_wrap ? '0 : tail_eff;
    assign alloc_index_o = SW'(alloc_start) << SlotShift;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o && (alloc_slots_w != '0);
    // A wrap also consumes the unusable tail slots as a pre-freed padding entry.
    assign alloc_delta   = alloc_wrap ? (tail_room + alloc_k) : alloc_k;

    assign free_slots_w  = to_slots(free_size_i);
    assign free_fire     = free_valid_i && (free_slots_w != '0);
    assign free_slot     = IW'(free_index_i >> SlotShift);

    assign retire        = !empty && freed_q[head_q];
    assign retire_len    = len_q[head_q];

    assign used_d = used_q + (alloc_fire ? alloc_delta : '0) - (retire ? retire_len : '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            used_q  <= '0;
            freed_q <= '0;
            len_q   <= '{default: '0};
        end else begin
            used_q <= used_d;
            if (retire) begin
                head_q          <= head_q + IW'(retire_len);
                freed_q[head_q] <= 1'b0;
            end else if (alloc_fire && empty) begin
                head_q <= '0;
            end
            if (free_fire) begin
                freed_q[free_slot] <= 1'b1;
            end
            if (alloc_fire) begin
                if (alloc_wrap) begin
                    len_q[tail_eff]   <= tail_room;
                    freed_q[tail_eff] <= 1'b1;
                    len_q[0]          <= alloc_k;
                    freed_q[0]        <= 1'b0;
                    tail_q            <= IW'(alloc_k);
                end else begin
                    len_q[alloc_start]   <= alloc_k;
                    freed_q[alloc_start] <= 1'b0;
                    tail_q               <= tail_eff + IW'(alloc_k);
                end
            end
        end
    end

    // Requests that do not fit are dropped; flag them in simulation.
    assert property (@(posedge clk_i) disable iff (!rst_ni) alloc_valid_i |-> alloc_ready_o);

endmodule

// File: tb/tb_pkt_buff_ring_alloc.sv
// Scenario bench for pkt_buff_ring_alloc with a queue of expected results.
module tb_pkt_buff_ring_alloc;

    localparam int unsigned BuffMemLength = 512;
    localparam int unsigned MemSlotSize   = 64;
    localparam int unsigned SW            = $clog2(BuffMemLength);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          alloc_valid_i = 1'b0;
    logic          alloc_ready_o;
    logic [SW:0]   alloc_size_i = '0;
    logic [SW-1:0] alloc_index_o;
    logic          free_valid_i = 1'b0;
    logic [SW-1:0] free_index_i = '0;
    logic [SW:0]   free_size_i = '0;
    logic [SW:0]   free_space_o;

    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] exp;
    int n_cmp  = 0;
    int n_fail = 0;

    pkt_buff_ring_alloc #(
        .BuffMemLength(BuffMemLength),
        .MemSlotSize  (MemSlotSize)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_valid_i(alloc_valid_i),
        .alloc_ready_o(alloc_ready_o),
        .alloc_size_i (alloc_size_i),
        .alloc_index_o(alloc_index_o),
        .free_valid_i (free_valid_i),
        .free_index_i (free_index_i),
        .free_size_i  (free_size_i),
        .free_space_o (free_space_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_free(input int idx, input int size);
        free_valid_i = 1'b1;
        free_index_i = SW'(idx);
        free_size_i  = (SW+1)'(size);
        tick();
        free_valid_i = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        for (int c = 0; c < limit && free_space_o !== (SW+1)'(BuffMemLength); c++) tick();
    endtask

    task automatic test_reset();
        alloc_size_i = (SW+1)'(512);
        exp_q.push_back(512); exp_q.push_back(1); exp_q.push_back(0);
        #1;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_free_space: got %0d want %0d", got, exp); end
        got = 32'(alloc_ready_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_ready_512: got %0d want %0d", got, exp); end
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_index: got %0d want %0d", got, exp); end
    endtask

    task automatic test_alloc();
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(100);
        exp_q.push_back(0); exp_q.push_back(384);
        #1;
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL alloc100_index: got %0d want %0d", got, exp); end
        tick();
        alloc_size_i = (SW+1)'(64);
        exp_q.push_back(128); exp_q.push_back(320);
        #1;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL alloc100_space: got %0d want %0d", got, exp); end
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL alloc64_index: got %0d want %0d", got, exp); end
        tick();
        alloc_valid_i = 1'b0;
        #1;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL alloc64_space: got %0d want %0d", got, exp); end
    endtask

    task automatic test_ooo_free();
        do_free(128, 64);
        exp_q.push_back(320);
        tick();
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ooo_parked_space: got %0d want %0d", got, exp); end
        do_free(0, 100);
        exp_q.push_back(512);
        wait_empty(3);
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL ooo_drained_space: got %0d want %0d", got, exp); end
    endtask

    task automatic test_wrap();
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(320);
        exp_q.push_back(0);
        #1;
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_a320_index: got %0d want %0d", got, exp); end
        tick();
        alloc_size_i = (SW+1)'(128);
        exp_q.push_back(320); exp_q.push_back(64);
        #1;
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_a128_index: got %0d want %0d", got, exp); end
        tick();
        alloc_valid_i = 1'b0;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_nearly_full_space: got %0d want %0d", got, exp); end
        do_free(0, 320);
        tick();
        exp_q.push_back(320);
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_retired_space: got %0d want %0d", got, exp); end
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(256);
        exp_q.push_back(0); exp_q.push_back(64);
        #1;
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_a256_index: got %0d want %0d", got, exp); end
        tick();
        alloc_valid_i = 1'b0;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_padded_space: got %0d want %0d", got, exp); end
        do_free(320, 128);
        do_free(0, 256);
        exp_q.push_back(512);
        wait_empty(6);
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL wrap_drained_space: got %0d want %0d", got, exp); end
    endtask

    task automatic test_full();
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(512);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        #1;
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL full_a512_index: got %0d want %0d", got, exp); end
        tick();
        alloc_valid_i = 1'b0; alloc_size_i = (SW+1)'(1);
        #1;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL full_space: got %0d want %0d", got, exp); end
        got = 32'(alloc_ready_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL full_ready_size1: got %0d want %0d", got, exp); end
        alloc_valid_i = 1'b1; alloc_size_i = '0;
        exp_q.push_back(1); exp_q.push_back(0);
        #1;
        got = 32'(alloc_ready_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL full_ready_size0: got %0d want %0d", got, exp); end
        tick();
        alloc_valid_i = 1'b0;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL full_after_zero_alloc: got %0d want %0d", got, exp); end
        do_free(0, 512);
        exp_q.push_back(512);
        wait_empty(3);
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL full_drained_space: got %0d want %0d", got, exp); end
    endtask

    task automatic test_concurrent();
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(64);
        tick();
        alloc_valid_i = 1'b0;
        do_free(0, 64);
        // slot 0 retires on the same edge that takes this allocation
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(64);
        exp_q.push_back(64); exp_q.push_back(384); exp_q.push_back(384);
        #1;
        got = 32'(alloc_index_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL conc_index: got %0d want %0d", got, exp); end
        tick();
        alloc_valid_i = 1'b0;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL conc_space: got %0d want %0d", got, exp); end
        tick();
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL conc_space_stable: got %0d want %0d", got, exp); end
        do_free(64, 64);
        exp_q.push_back(512);
        wait_empty(3);
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL conc_drained_space: got %0d want %0d", got, exp); end
    endtask

    task automatic test_reset_mid();
        alloc_valid_i = 1'b1; alloc_size_i = (SW+1)'(192);
        tick();
        alloc_valid_i = 1'b0;
        exp_q.push_back(320); exp_q.push_back(512); exp_q.push_back(512);
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_pre_space: got %0d want %0d", got, exp); end
        #2 rst_ni = 1'b0;
        #1;
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_async_space: got %0d want %0d", got, exp); end
        tick();
        rst_ni = 1'b1;
        tick();
        got = 32'(free_space_o); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_fail++; $display("FAIL rst_post_space: got %0d want %0d", got, exp); end
    endtask

    initial begin
        #12 rst_ni = 1'b1;
        tick();
        test_reset();
        test_alloc();
        test_ooo_free();
        test_wrap();
        test_full();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
